// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared half-precision format constants, types and classifier
package float_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int MANT_W = FRAC_W + 1;
  localparam int BIAS   = 15;
  localparam logic [15:0] QNAN = 16'h7e00;
  localparam logic [15:0] INF  = 16'h7c00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_POST,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    C_ZERO,
    C_SUB,
    C_NORM,
    C_INF,
    C_NAN
  } fclass_t;

  function automatic fclass_t classify(input logic [15:0] x);
    logic [EXP_W-1:0]  ex;
    logic [FRAC_W-1:0] fr;
    ex = x[FRAC_W +: EXP_W];
    fr = x[FRAC_W-1:0];
    if (ex == '1)      return (fr != '0) ? C_NAN : C_INF;
    else if (ex == '0) return (fr != '0) ? C_SUB : C_ZERO;
    else               return C_NORM;
  endfunction

endpackage

// File: rtl/float_divider_if.sv
// rtl/float_divider_if.sv - request/result bundle between a requester and the divider
interface float_divider_if;
  logic        start;
  logic [15:0] num1;
  logic [15:0] num2;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        zero;
  logic        nan;
  logic        precisionLost;

  modport master (
    output start, num1, num2,
    input  result, busy, done, overflow, zero, nan, precisionLost
  );

  modport slave (
    input  start, num1, num2,
    output result, busy, done, overflow, zero, nan, precisionLost
  );
endinterface

// File: rtl/float_normalize.sv
// rtl/float_normalize.sv - classify an operand and produce normalized mantissa and exponent
import float_pkg::*;

module float_normalize (
  input  logic [15:0]        num,
  output fclass_t            cls,
  output logic [MANT_W-1:0]  mant,
  output logic signed [7:0]  exp
);

  logic [3:0] lz;

  // Subnormals get exponent 1, then shift the leading one up to the hidden position.
  always_comb begin
    cls = classify(num);
    lz  = '0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (num[i]) lz = 4'(FRAC_W - i);
    end
    if (cls == C_SUB) begin
      mant = {1'b0, num[FRAC_W-1:0]} << lz;
      exp  = 8'sd1 - $signed({4'd0, lz});
    end else begin
      mant = {1'b1, num[FRAC_W-1:0]};
      exp  = $signed({3'd0, num[FRAC_W +: EXP_W]});
    end
  end

endmodule

// File: rtl/float_divider.sv
// rtl/float_divider.sv - sequential restoring half-precision divider with start/done handshake
import float_pkg::*;

module float_divider (
  input  logic          clk,
  input  logic          rst_n,
  float_divider_if.slave bus
);

  state_t state, state_nxt;

  logic [15:0]        a_r, b_r;
  logic [4:0]         step;
  logic [11:0]        rem;
  logic [MANT_W-1:0]  q, m2_r;
  logic signed [7:0]  e_r;
  logic               sign_r, special_r;
  logic [15:0]        spec_res;
  logic               spec_ovf, spec_zero, spec_nan;
  logic [15:0]        res_r;
  logic               ovf_r, zero_r, nan_r, lost_r;

  fclass_t            c1, c2;
  logic [MANT_W-1:0]  m1, m2;
  logic signed [7:0]  e1, e2;

  float_normalize u_norm1 (.num(a_r), .cls(c1), .mant(m1), .exp(e1));
  float_normalize u_norm2 (.num(b_r), .cls(c2), .mant(m2), .exp(e2));

  logic               sgn, is_special, sp_ovf, sp_zero, sp_nan;
  logic [15:0]        sp_res;
  logic signed [7:0]  e_init;
  logic [11:0]        rem_init, rem_diff;
  logic               take;

  // Special-operand detection, highest priority first.
  always_comb begin
    sgn        = a_r[15] ^ b_r[15];
    is_special = 1'b1;
    sp_res     = {sgn, 15'd0};
    sp_ovf     = 1'b0;
    sp_zero    = 1'b0;
    sp_nan     = 1'b0;
    if (c1 == C_NAN || c2 == C_NAN || (c1 == C_ZERO && c2 == C_ZERO) ||
        (c1 == C_INF && c2 == C_INF)) begin
      sp_res = QNAN;
      sp_nan = 1'b1;
    end else if (c1 == C_INF) begin
      sp_res = {sgn, INF[14:0]};
    end else if (c2 == C_ZERO) begin
      sp_res = {sgn, INF[14:0]};
      sp_ovf = 1'b1;
    end else if (c1 == C_ZERO || c2 == C_INF) begin
      sp_zero = 1'b1;
    end else begin
      is_special = 1'b0;
    end
  end

  // Pre-align the dividend so the first quotient bit is always one.
  always_comb begin
    e_init = e1 - e2 + $signed(8'(BIAS));
    if (m1 < m2) begin
      rem_init = {m1, 1'b0};
      e_init   = e_init - 8'sd1;
    end else begin
      rem_init = {1'b0, m1};
    end
    rem_diff = rem - {1'b0, m2_r};
    take     = rem >= {1'b0, m2_r};
  end

  logic [15:0]        post_res;
  logic               post_ovf, post_zero, post_nan, post_lost;
  logic signed [7:0]  sh;
  logic [MANT_W-1:0]  q_sh;

  // Pack the quotient: saturate, denormalize with truncation, or pack normally.
  always_comb begin
    sh        = 8'sd1 - e_r;
    q_sh      = q;
    post_res  = {sign_r, e_r[4:0], q[FRAC_W-1:0]};
    post_ovf  = 1'b0;
    post_zero = 1'b0;
    post_nan  = 1'b0;
    post_lost = rem != '0;
    if (special_r) begin
      post_res  = spec_res;
      post_ovf  = spec_ovf;
      post_zero = spec_zero;
      post_nan  = spec_nan;
      post_lost = 1'b0;
    end else if (e_r >= 8'sd31) begin
      post_res = {sign_r, INF[14:0]};
      post_ovf = 1'b1;
    end else if (e_r <= 8'sd0) begin
      if (sh > 8'sd11) begin
        post_res  = {sign_r, 15'd0};
        post_zero = 1'b1;
        post_lost = 1'b1;
      end else begin
        q_sh      = q >> sh[3:0];
        post_res  = {sign_r, 5'd0, q_sh[FRAC_W-1:0]};
        post_zero = q_sh == '0;
        post_lost = (rem != '0) || ((q_sh << sh[3:0]) != q);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_PREP;
      S_PREP: state_nxt = is_special ? S_POST : S_DIV;
      S_DIV:  if (step == 5'd10) state_nxt = S_POST;
      S_POST: state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.busy = state != S_IDLE;
    bus.done = state == S_DONE;
  end

  // Operand latch, restoring division steps and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r <= '0; b_r <= '0; step <= '0; rem <= '0; q <= '0; m2_r <= '0;
      e_r <= '0; sign_r <= 1'b0; special_r <= 1'b0; spec_res <= '0;
      spec_ovf <= 1'b0; spec_zero <= 1'b0; spec_nan <= 1'b0;
      res_r <= '0; ovf_r <= 1'b0; zero_r <= 1'b0; nan_r <= 1'b0; lost_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          a_r <= bus.num1;
          b_r <= bus.num2;
        end
        S_PREP: begin
          special_r <= is_special;
          spec_res  <= sp_res;
          spec_ovf  <= sp_ovf;
          spec_zero <= sp_zero;
          spec_nan  <= sp_nan;
          sign_r    <= sgn;
          rem       <= rem_init;
          e_r       <= e_init;
          m2_r      <= m2;
          q         <= '0;
          step      <= '0;
        end
        S_DIV: begin
          rem  <= take ? {rem_diff[10:0], 1'b0} : {rem[10:0], 1'b0};
          q    <= {q[FRAC_W-1:0], take};
          step <= step + 5'd1;
        end
        S_POST: begin
          res_r  <= post_res;
          ovf_r  <= post_ovf;
          zero_r <= post_zero;
          nan_r  <= post_nan;
          lost_r <= post_lost;
        end
        default: ;
      endcase
    end
  end

  assign bus.result        = res_r;
  assign bus.overflow      = ovf_r;
  assign bus.zero          = zero_r;
  assign bus.nan           = nan_r;
  assign bus.precisionLost = lost_r;

endmodule

// File: tb/tb_float_divider.sv
// tb/tb_float_divider.sv - scoreboard bench for float_divider with directed vectors
module tb_float_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  float_divider_if bus ();

  float_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [19:0] want;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [19:0] mon_got;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      checks++;
      mon_got = {bus.result, bus.overflow, bus.zero, bus.nan, bus.precisionLost};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done result=%h flags=%b", bus.result, mon_got[3:0]);
      end else begin
        mon_e = sb.pop_front();
        if (mon_got !== mon_e.want || cyc + 1 != mon_e.cyc) begin
          errors++;
          $display("FAIL div_%h_%h got result=%h ovf/zero/nan/lost=%b cycle=%0d, want result=%h flags=%b cycle=%0d",
                   mon_e.a, mon_e.b, mon_got[19:4], mon_got[3:0], cyc + 1,
                   mon_e.want[19:4], mon_e.want[3:0], mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Issue one division; lat is the spec cycle of done counted from the accepting edge.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                     input logic ovf, input logic zer, input logic nan, input logic lost,
                     input int lat, input bit poke);
    exp_t e;
    int   k;
    int   i;
    bit   busy_ok;
    bus.num1  = a;
    bus.num2  = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = cyc;
    bus.start = 1'b0;
    e.a = a; e.b = b; e.want = {res, ovf, zer, nan, lost}; e.cyc = k + lat;
    sb.push_back(e);
    busy_ok = 1'b1;
    i = 0;
    while (!bus.done && i < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (poke && i == 3) begin
        bus.num1  = 16'h4000;
        bus.num2  = 16'h4000;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      i++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL timeout_%h_%h no done within 40 cycles", a, b);
    end
    if (!bus.busy) busy_ok = 1'b0;
    check("busy_while_running", {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    check("idle_after_done", {14'd0, bus.busy, bus.done, bus.result}, {16'd0, res});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.start = 1'b0;
    bus.num1  = '0;
    bus.num2  = '0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {11'd0, bus.busy, bus.done, bus.overflow, bus.zero, bus.nan, bus.precisionLost, bus.result},
          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //   a        b        result   ovf   zero  nan   lost  lat poke
    run(16'h3c00, 16'h3c00, 16'h3c00, 1'b0, 1'b0, 1'b0, 1'b0, 14, 1'b0);
    run(16'h4600, 16'h4000, 16'h4200, 1'b0, 1'b0, 1'b0, 1'b0, 14, 1'b0);
    run(16'h3c00, 16'h4200, 16'h3555, 1'b0, 1'b0, 1'b0, 1'b1, 14, 1'b1);
    run(16'h3c00, 16'h0000, 16'h7c00, 1'b1, 1'b0, 1'b0, 1'b0,  3, 1'b0);
    run(16'h0000, 16'h0000, 16'h7e00, 1'b0, 1'b0, 1'b1, 1'b0,  3, 1'b0);
    run(16'h4000, 16'h7c00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0,  3, 1'b0);
    run(16'h7bff, 16'h3800, 16'h7c00, 1'b1, 1'b0, 1'b0, 1'b0, 14, 1'b0);
    run(16'hc600, 16'h4000, 16'hc200, 1'b0, 1'b0, 1'b0, 1'b0, 14, 1'b0);
    run(16'h0400, 16'h4000, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 14, 1'b0);
    run(16'h0001, 16'h3c00, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 14, 1'b0);
    run(16'h7e00, 16'h3c00, 16'h7e00, 1'b0, 1'b0, 1'b1, 1'b0,  3, 1'b0);
    run(16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0,  3, 1'b0);
    run(16'h0400, 16'h7800, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 14, 1'b0);

    // Abort in the middle of the division: DIV step 5 is spec cycle k+7.
    bus.num1  = 16'h3c00;
    bus.num2  = 16'h3c00;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = cyc;
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("at_div_step5_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_reset_state",
          {11'd0, bus.busy, bus.done, bus.overflow, bus.zero, bus.nan, bus.precisionLost, bus.result},
          32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", {31'd0, bus.busy}, 32'd0);
    run(16'h3c00, 16'h3c00, 16'h3c00, 1'b0, 1'b0, 1'b0, 1'b0, 14, 1'b0);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
